// File: rtl/sram_buf_ctrl_pkg.sv
// sram_buf_ctrl_pkg: shared sizes and state encoding for the receive SRAM buffer controller
package sram_buf_ctrl_pkg;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;
endpackage

// File: rtl/sram_buf_ctrl_if.sv
// sram_buf_ctrl_if: deserializer, SRAM and transmitter signals of the buffer controller
interface sram_buf_ctrl_if;
  import sram_buf_ctrl_pkg::*;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] sram_wdata;
  logic          sram_we;
  logic          sram_re;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  modport master (
    input  rx_data, rx_valid, sram_rdata, tx_ready,
    output sram_wdata, sram_we, sram_re, sram_addr, tx_data, tx_valid, count, full, empty, overflow
  );
  modport slave (
    output rx_data, rx_valid, sram_rdata, tx_ready,
    input  sram_wdata, sram_we, sram_re, sram_addr, tx_data, tx_valid, count, full, empty, overflow
  );
endinterface

// File: rtl/sram_buf_ctrl.sv
// sram_buf_ctrl: circular write/read pointer control of a single-port SRAM feeding a valid/ready output
module sram_buf_ctrl
  import sram_buf_ctrl_pkg::*;
(
  input logic            clk,
  input logic            rst,
  sram_buf_ctrl_if.master bus
);
  state_t        state, state_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [DW-1:0] tx_data_q;
  logic          tx_valid_q, ovf_q, full, empty, wr, rd;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  // writes take the single SRAM port first; a blocked read issue simply retries next cycle
  assign wr = bus.rx_valid && !full;
  assign rd = state == IDLE && !wr && !empty && !tx_valid_q;
  assign bus.sram_we    = !rst && wr;
  assign bus.sram_re    = !rst && rd;
  assign bus.sram_addr  = rst ? '0 : wr ? wr_ptr : rd_ptr;
  assign bus.sram_wdata = bus.rx_data;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.count      = cnt;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.overflow   = ovf_q;
  always_comb begin
    state_nx = state == IDLE ? (rd ? RD_WAIT : IDLE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state  <= state_nx;
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(rd);
      cnt    <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
      ovf_q  <= ovf_q || (bus.rx_valid && full);
      if (state == RD_WAIT) begin
        tx_data_q  <= bus.sram_rdata;
        tx_valid_q <= 1'b1;
      end else if (tx_valid_q && bus.tx_ready) begin
        tx_valid_q <= 1'b0;
      end
    end
  end
endmodule
